// File: rtl/immgen_pkg.sv
// Shared encodings for the immediate generator: format codes, skid states,
// RV base opcodes and the per-XLEN opcode legality check.
package immgen_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_NONE = 3'd7
    } fmt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;

    // Word-sized (*W) opcodes only exist on RV64.
    function automatic logic xlen_legal(input logic [6:0] op, input int xlen);
        if (op == OP_OP_32 || op == OP_IMM_32) return (xlen == 64);
        return 1'b1;
    endfunction

endpackage

// File: rtl/immgen_decode.sv
// Combinational RV immediate decode: instruction word -> {imm, fmt, illegal}.
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              is_shift;
    logic signed [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;
    logic [5:0]        shamt, shamt_w;

    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'd1) || (funct3 == 3'd5);

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};

    // Bit 30 (arith/logical select) never leaks into the shift amount.
    assign shamt   = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    assign shamt_w = {1'b0, instr[24:20]};

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11 || !xlen_legal(op, XLEN)) begin
            illegal = 1'b1;
        end else begin
            case (op)
                OP_LUI, OP_AUIPC: begin
                    fmt = FMT_U;
                    imm = XLEN'(u_imm);
                end
                OP_LOAD, OP_JALR, OP_MISC_MEM, OP_SYSTEM: begin
                    fmt = FMT_I;
                    imm = XLEN'(i_imm);
                end
                OP_STORE: begin
                    fmt = FMT_S;
                    imm = XLEN'(s_imm);
                end
                OP_BRANCH: begin
                    fmt = FMT_B;
                    imm = XLEN'(b_imm);
                end
                OP_JAL: begin
                    fmt = FMT_J;
                    imm = XLEN'(j_imm);
                end
                OP_OP, OP_OP_32: fmt = FMT_R;
                OP_IMM: begin
                    fmt = is_shift ? FMT_SH : FMT_I;
                    imm = is_shift ? XLEN'(shamt) : XLEN'(i_imm);
                end
                OP_IMM_32: begin
                    fmt = is_shift ? FMT_SH : FMT_I;
                    imm = is_shift ? XLEN'(shamt_w) : XLEN'(i_imm);
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator: one-cycle decode into a 2-entry skid
// buffer so in_ready is purely a registered signal.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_ill;

    immgen_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    skid_state_t state, state_nxt;
    logic        rdy_q;
    logic        acc, pop;
    logic        ld_main_in, ld_main_skid, ld_skid;

    fmt_t            main_fmt, skid_fmt;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_imm;
    logic            skid_ill;

    assign in_ready = rdy_q;
    assign acc      = in_valid && rdy_q;
    assign pop      = (state != SKID_EMPTY) && out_ready;
    assign out_fmt  = main_fmt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SKID_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: if (acc) state_nxt = SKID_ONE;
                SKID_ONE: begin
                    if (acc && !pop)      state_nxt = SKID_TWO;
                    else if (pop && !acc) state_nxt = SKID_EMPTY;
                end
                SKID_TWO:   if (pop) state_nxt = SKID_ONE;
                default:    state_nxt = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid    = (state != SKID_EMPTY);
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (!flush) begin
            case (state)
                SKID_EMPTY: ld_main_in = acc;
                SKID_ONE: begin
                    ld_main_in = acc && pop;
                    ld_skid    = acc && !pop;
                end
                SKID_TWO:   ld_main_skid = pop;
                default: ;
            endcase
        end
    end

    // Ready is 0 in reset and tracks the state the buffer is about to enter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= (state_nxt != SKID_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_instr   <= '0;
            out_imm     <= '0;
            main_fmt    <= FMT_NONE;
            out_illegal <= 1'b0;
        end else if (ld_main_in) begin
            out_instr   <= in_instr;
            out_imm     <= dec_imm;
            main_fmt    <= dec_fmt;
            out_illegal <= dec_ill;
        end else if (ld_main_skid) begin
            out_instr   <= skid_instr;
            out_imm     <= skid_imm;
            main_fmt    <= skid_fmt;
            out_illegal <= skid_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instr <= '0;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
            skid_ill   <= 1'b0;
        end else if (ld_skid) begin
            skid_instr <= in_instr;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances side by side.
module tb_immgen_pipe;
    import immgen_pkg::*;

    logic clk, rst;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, out_instr, out_imm;
    logic [2:0]  out_fmt;

    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
    logic [31:0] w_in_instr, w_out_instr;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_fmt;

    int n_checks = 0;
    int n_fail   = 0;

    immgen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    immgen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
        .out_imm(w_out_imm), .out_fmt(w_out_fmt), .out_illegal(w_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Single transfer from an empty buffer with out_ready=1.
    task automatic send32(input string tag, input logic [31:0] ins, input logic [31:0] eimm,
                          input logic [2:0] efmt, input logic eill);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_imm"}, out_imm, eimm);
        chk({tag, "_fmt"}, out_fmt, efmt);
        chk({tag, "_ill"}, out_illegal, eill);
        @(negedge clk);
    endtask

    task automatic send64(input string tag, input logic [31:0] ins, input logic [63:0] eimm,
                          input logic [2:0] efmt, input logic eill);
        @(negedge clk);
        w_in_valid = 1'b1;
        w_in_instr = ins;
        @(negedge clk);
        w_in_valid = 1'b0;
        chk({tag, "_vld"}, w_out_valid, 1'b1);
        chk({tag, "_imm"}, w_out_imm, eimm);
        chk({tag, "_fmt"}, w_out_fmt, efmt);
        chk({tag, "_ill"}, w_out_illegal, eill);
        @(negedge clk);
    endtask

    logic [31:0] s_in  [4] = '{32'hFFF00093, 32'h12345037, 32'hFFDFF06F, 32'h00000463};
    logic [31:0] s_imm [4] = '{32'hFFFFFFFF, 32'h12345000, 32'hFFFFFFFC, 32'h00000008};
    logic [2:0]  s_fmt [4] = '{FMT_I, FMT_U, FMT_J, FMT_B};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = '0; w_out_ready = 1'b1;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_fmt", out_fmt, FMT_NONE);
        chk("rst_imm", out_imm, 32'h0);
        rst = 1'b0;
        #1 chk("rel_rdy_pre", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("rel_rdy_post", in_ready, 1'b1);
        chk("rel_rdy64", w_in_ready, 1'b1);
        chk("rel_vld", out_valid, 1'b0);

        // back-to-back stream
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = s_in[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("strm_vld", out_valid, 1'b1);
            chk("strm_rdy", in_ready, 1'b1);
            chk("strm_instr", out_instr, s_in[i]);
            chk("strm_imm", out_imm, s_imm[i]);
            chk("strm_fmt", out_fmt, s_fmt[i]);
            if (i < 3) in_instr = s_in[i+1];
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        chk("strm_drain", out_valid, 1'b0);

        // extra decode cases on XLEN=32
        send32("w_op32", 32'h0000001B, 32'h0, FMT_NONE, 1'b1);
        send32("opw_32", 32'h0000003B, 32'h0, FMT_NONE, 1'b1);
        send32("lo_bits", 32'h00000000, 32'h0, FMT_NONE, 1'b1);
        send32("sw", 32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0);
        send32("add", 32'h00208033, 32'h0, FMT_R, 1'b0);
        send32("srai32", 32'h4030D093, 32'h00000003, FMT_SH, 1'b0);

        // backpressure: two accepted, third held off, drain in order
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        @(negedge clk);
        chk("bp_rdy1", in_ready, 1'b1);
        in_instr = 32'h12345037;
        @(negedge clk);
        chk("bp_rdy2", in_ready, 1'b0);
        in_instr = 32'h00000463;
        @(negedge clk);
        chk("bp_hold_rdy", in_ready, 1'b0);
        chk("bp_head", out_instr, 32'hFFF00093);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_d1_vld", out_valid, 1'b1);
        chk("bp_d1", out_instr, 32'h12345037);
        chk("bp_d1_rdy", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_d2", out_instr, 32'h00000463);
        chk("bp_d2_imm", out_imm, 32'h00000008);
        @(negedge clk);
        chk("bp_empty", out_valid, 1'b0);

        // flush in TWO with a simultaneous input
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093;
        @(negedge clk);
        in_instr = 32'h12345037;
        @(negedge clk);
        chk("fl_two", in_ready, 1'b0);
        flush = 1'b1; in_instr = 32'hFFDFF06F;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_vld", out_valid, 1'b0);
        chk("fl_rdy", in_ready, 1'b1);
        @(negedge clk);
        chk("fl_gone", out_valid, 1'b0);

        // async reset between edges with one entry buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h12345037;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", out_valid, 1'b0);
        chk("ar_rdy", in_ready, 1'b0);
        chk("ar_instr", out_instr, 32'h0);
        chk("ar_imm", out_imm, 32'h0);
        chk("ar_fmt", out_fmt, FMT_NONE);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        send32("ar_resume", 32'hFFF00093, 32'hFFFFFFFF, FMT_I, 1'b0);

        // XLEN=64
        send64("srai64", 32'h4230D093, 64'h0000000000000023, FMT_SH, 1'b0);
        send64("addi64", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
        send64("addiw", 32'h0000001B, 64'h0, FMT_I, 1'b0);
        send64("sraiw", 32'h4230D01B, 64'h0000000000000003, FMT_SH, 1'b0);
        send64("lui64", 32'h80000037, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
        send64("addw", 32'h0000003B, 64'h0, FMT_R, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
